// File: rtl/cpu_bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one split-transaction SRAM-like bus.
// An ID FIFO routes each in-order data-phase response back to the master that issued it.
module cpu_bus_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_req,
    input  logic [31:0]              inst_addr,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [31:0]              inst_rdata,
    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [3:0]               data_wstrb,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [31:0]              data_rdata,
    output logic                     bus_req,
    output logic                     bus_wr,
    output logic [3:0]               bus_wstrb,
    output logic [31:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    input  logic                     bus_addr_ok,
    input  logic                     bus_data_ok,
    input  logic [31:0]              bus_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_orphan
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic       ID_INST = 1'b0;
    localparam logic       ID_DATA = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic [DEPTH-1:0] ids_q, ids_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             err_q, err_d;

    logic gnt, gnt_req, full, empty, starved, push, pop, head;

    // Grant and bus mux: purely combinational so req -> bus_req has no latency.
    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty   = (cnt_q == '0);
        starved = (starve_q == SW'(STARVE_LIMIT)) && inst_req;
        if (state_q == ST_LOCK)          gnt = lock_id_q;
        else if (data_req && !starved)   gnt = ID_DATA;
        else                             gnt = ID_INST;
        gnt_req = (gnt == ID_DATA) ? data_req : inst_req;
        bus_req = gnt_req && !full;
        if (gnt == ID_DATA) begin
            bus_wr    = data_wr;
            bus_wstrb = data_wstrb;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
        end else begin
            bus_wr    = 1'b0;
            bus_wstrb = 4'b0000;
            bus_addr  = inst_addr;
            bus_wdata = 32'h0;
        end
        push         = bus_req && bus_addr_ok;
        inst_addr_ok = push && (gnt == ID_INST);
        data_addr_ok = push && (gnt == ID_DATA);
        pop          = bus_data_ok && !empty;
        head         = ids_q[rd_ptr_q];
        inst_data_ok = pop && (head == ID_INST);
        data_data_ok = pop && (head == ID_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
        outstanding  = cnt_q;
        err_orphan   = err_q;
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ST_IDLE: if (bus_req && !bus_addr_ok) begin
                state_d   = ST_LOCK;
                lock_id_d = gnt;
            end
            // A locked master dropping req is illegal but must not wedge the bus.
            ST_LOCK: if (bus_addr_ok || !gnt_req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            ids_d[wr_ptr_q] = gnt;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        starve_d = starve_q;
        if (!inst_req || inst_addr_ok)
            starve_d = '0;
        else if (data_addr_ok && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);

        err_d = err_q | (bus_data_ok && empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lock_id_q <= ID_INST;
            ids_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ids_q     <= ids_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_cpu_bus_arbiter;

    localparam int DEPTH = 4;
    localparam int SLIM  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, data_wr, bus_addr_ok, bus_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr, err_orphan;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [2:0]  outstanding;

    int n_chk = 0;
    int n_pass = 0;

    cpu_bus_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    wire [4:0] oks = {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        inst_req = 0; data_req = 0; data_wr = 0; bus_addr_ok = 0; bus_data_ok = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0; bus_rdata = 0; data_wstrb = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr();
        step(); #1;
        n_chk++; if (outstanding !== 3'd0) $display("FAIL reset_outstanding got %0d exp 0", outstanding); else n_pass++;
        n_chk++; if (err_orphan !== 1'b0) $display("FAIL reset_err got %b exp 0", err_orphan); else n_pass++;
        n_chk++; if (oks !== 5'b00000) $display("FAIL reset_oks got %b exp 00000", oks); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        clr(); inst_req = 1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1;
        #1;
        n_chk++; if (oks !== 5'b11000) $display("FAIL fetch_addr_oks got %b exp 11000", oks); else n_pass++;
        n_chk++; if ({bus_addr, bus_wr, bus_wstrb} !== {32'hBFC0_0000, 1'b0, 4'b0000})
            $display("FAIL fetch_bus got %h/%b/%b exp bfc00000/0/0000", bus_addr, bus_wr, bus_wstrb); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (outstanding !== 3'd1) $display("FAIL fetch_outstanding got %0d exp 1", outstanding); else n_pass++;
        step();
        bus_data_ok = 1; bus_rdata = 32'h3C1D_8000; #1;
        n_chk++; if (oks !== 5'b00010) $display("FAIL fetch_data_oks got %b exp 00010", oks); else n_pass++;
        n_chk++; if (inst_rdata !== 32'h3C1D_8000) $display("FAIL fetch_rdata got %h exp 3c1d8000", inst_rdata); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (outstanding !== 3'd0) $display("FAIL fetch_drain got %0d exp 0", outstanding); else n_pass++;
    endtask

    task automatic test_contention();
        clr(); inst_req = 1; inst_addr = 32'hBFC0_0010;
        data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h8000_1000;
        data_wdata = 32'h1234_5678; bus_addr_ok = 1; #1;
        n_chk++; if (oks !== 5'b10100) $display("FAIL cont_first_oks got %b exp 10100", oks); else n_pass++;
        n_chk++; if ({bus_addr, bus_wr, bus_wstrb, bus_wdata} !== {32'h8000_1000, 1'b1, 4'b0011, 32'h1234_5678})
            $display("FAIL cont_first_bus got %h/%b/%b/%h exp 80001000/1/0011/12345678", bus_addr, bus_wr, bus_wstrb, bus_wdata); else n_pass++;
        step(); data_req = 0; #1;
        n_chk++; if (oks !== 5'b11000 || bus_addr !== 32'hBFC0_0010)
            $display("FAIL cont_second got %b/%h exp 11000/bfc00010", oks, bus_addr); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (outstanding !== 3'd2) $display("FAIL cont_outstanding got %0d exp 2", outstanding); else n_pass++;
        bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00001) $display("FAIL cont_resp1 got %b exp 00001", oks); else n_pass++;
        step(); #1;
        n_chk++; if (oks !== 5'b00010) $display("FAIL cont_resp2 got %b exp 00010", oks); else n_pass++;
        step(); clr();
    endtask

    task automatic test_lock();
        clr(); inst_req = 1; inst_addr = 32'hBFC0_0200; data_addr = 32'h8000_4000;
        for (int c = 0; c < 3; c++) begin
            data_req = (c >= 1); #1;
            n_chk++; if (!bus_req || bus_addr !== 32'hBFC0_0200 || data_addr_ok)
                $display("FAIL lock_hold%0d got %b/%h exp 1/bfc00200", c, bus_req, bus_addr); else n_pass++;
            step();
        end
        bus_addr_ok = 1; #1;
        n_chk++; if (oks !== 5'b11000 || bus_addr !== 32'hBFC0_0200)
            $display("FAIL lock_accept got %b/%h exp 11000/bfc00200", oks, bus_addr); else n_pass++;
        step(); inst_req = 0; #1;
        n_chk++; if (oks !== 5'b10100 || bus_addr !== 32'h8000_4000)
            $display("FAIL lock_after got %b/%h exp 10100/80004000", oks, bus_addr); else n_pass++;
        step(); clr(); bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00010) $display("FAIL lock_resp1 got %b exp 00010", oks); else n_pass++;
        step(); #1;
        n_chk++; if (oks !== 5'b00001) $display("FAIL lock_resp2 got %b exp 00001", oks); else n_pass++;
        step(); clr();
    endtask

    task automatic test_full();
        clr(); data_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < DEPTH; i++) begin
            data_addr = 32'h8000_0100 + 32'(i * 4); #1;
            n_chk++; if (oks !== 5'b10100) $display("FAIL full_load%0d got %b exp 10100", i, oks); else n_pass++;
            step();
        end
        #1;
        n_chk++; if (outstanding !== 3'd4 || oks !== 5'b00000)
            $display("FAIL full_block got %0d/%b exp 4/00000", outstanding, oks); else n_pass++;
        step(); bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00001) $display("FAIL full_pop got %b exp 00001", oks); else n_pass++;
        step(); bus_data_ok = 0; #1;
        n_chk++; if (outstanding !== 3'd3 || oks !== 5'b10100)
            $display("FAIL full_reopen got %0d/%b exp 3/10100", outstanding, oks); else n_pass++;
        step(); #1;
        n_chk++; if (outstanding !== 3'd4) $display("FAIL full_refill got %0d exp 4", outstanding); else n_pass++;
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_chk++; if (oks !== 5'b00001) $display("FAIL full_drain%0d got %b exp 00001", i, oks); else n_pass++;
            step();
        end
        clr(); #1;
        n_chk++; if (outstanding !== 3'd0) $display("FAIL full_empty got %0d exp 0", outstanding); else n_pass++;
    endtask

    task automatic test_starvation();
        clr(); inst_req = 1; data_req = 1; bus_addr_ok = 1;
        inst_addr = 32'hBFC0_0100; data_addr = 32'h8000_3000;
        for (int i = 0; i < SLIM + 2; i++) begin
            bus_data_ok = (i != 0); #1;
            n_chk++; if ({inst_addr_ok, data_addr_ok} !== ((i == SLIM) ? 2'b10 : 2'b01))
                $display("FAIL starve_grant%0d got %b exp %b", i, {inst_addr_ok, data_addr_ok}, (i == SLIM) ? 2'b10 : 2'b01);
            else n_pass++;
            step();
        end
        clr(); bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00001) $display("FAIL starve_tail got %b exp 00001", oks); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (outstanding !== 3'd0) $display("FAIL starve_empty got %0d exp 0", outstanding); else n_pass++;
    endtask

    task automatic test_orphan();
        clr(); bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00000) $display("FAIL orphan_oks got %b exp 00000", oks); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (err_orphan !== 1'b1) $display("FAIL orphan_err got %b exp 1", err_orphan); else n_pass++;
        n_chk++; if (outstanding !== 3'd0) $display("FAIL orphan_count got %0d exp 0", outstanding); else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        clr(); data_req = 1; data_addr = 32'h8000_5000; bus_addr_ok = 1;
        step(); clr(); inst_req = 1; inst_addr = 32'hBFC0_0300;
        step(); data_req = 1; data_addr = 32'h8000_2000; #1;
        n_chk++; if (bus_addr !== 32'hBFC0_0300 || outstanding !== 3'd1)
            $display("FAIL rst_prelock got %h/%0d exp bfc00300/1", bus_addr, outstanding); else n_pass++;
        #2 reset = 1'b1; #1;
        n_chk++; if (outstanding !== 3'd0 || err_orphan !== 1'b0)
            $display("FAIL rst_async got %0d/%b exp 0/0", outstanding, err_orphan); else n_pass++;
        n_chk++; if (bus_addr !== 32'h8000_2000 || !bus_req)
            $display("FAIL rst_idle got %h/%b exp 80002000/1", bus_addr, bus_req); else n_pass++;
        clr(); step(); reset = 1'b0;
        bus_data_ok = 1; #1;
        n_chk++; if (oks !== 5'b00000) $display("FAIL rst_orphan_oks got %b exp 00000", oks); else n_pass++;
        step(); clr(); #1;
        n_chk++; if (err_orphan !== 1'b1) $display("FAIL rst_orphan_err got %b exp 1", err_orphan); else n_pass++;
    endtask

    // Reference: ID queue, lock flag, starvation count and sticky error, updated per cycle.
    task automatic test_random(input int n);
        int  q[$];
        bit  locked, lock_id, m_err, g, greq, e_breq, e_hs, e_pop, e_head;
        int  starve;
        logic [4:0]  e_oks;
        logic [68:0] e_bus;
        reset = 1'b1; clr(); step(); reset = 1'b0;
        locked = 0; lock_id = 0; m_err = 0; starve = 0;
        for (int c = 0; c < n; c++) begin
            inst_req    = 1'($urandom_range(0, 1));
            data_req    = 1'($urandom_range(0, 1));
            data_wr     = 1'($urandom_range(0, 1));
            data_wstrb  = 4'($urandom);
            inst_addr   = $urandom;
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_rdata   = $urandom;
            bus_addr_ok = ($urandom_range(0, 3) != 0);
            bus_data_ok = ($urandom_range(0, 2) == 0);
            if (locked)                                 g = lock_id;
            else if (data_req && !(starve == SLIM && inst_req)) g = 1;
            else                                        g = 0;
            greq   = g ? data_req : inst_req;
            e_breq = greq && (q.size() < DEPTH);
            e_hs   = e_breq && bus_addr_ok;
            e_pop  = bus_data_ok && (q.size() > 0);
            e_head = e_pop ? 1'(q[0]) : 1'b0;
            e_oks  = {e_breq, e_hs && !g, e_hs && g, e_pop && !e_head, e_pop && e_head};
            e_bus  = g ? {data_addr, data_wr, data_wstrb, data_wdata} : {inst_addr, 1'b0, 4'b0000, 32'h0};
            #1;
            n_chk++; if (oks !== e_oks) $display("FAIL rand_oks c%0d got %b exp %b", c, oks, e_oks); else n_pass++;
            if (e_breq) begin
                n_chk++; if ({bus_addr, bus_wr, bus_wstrb, bus_wdata} !== e_bus)
                    $display("FAIL rand_bus c%0d got %h exp %h", c, {bus_addr, bus_wr, bus_wstrb, bus_wdata}, e_bus); else n_pass++;
            end
            n_chk++; if (outstanding !== 3'(q.size()) || err_orphan !== m_err)
                $display("FAIL rand_state c%0d got %0d/%b exp %0d/%b", c, outstanding, err_orphan, q.size(), m_err); else n_pass++;
            n_chk++; if (inst_rdata !== bus_rdata || data_rdata !== bus_rdata)
                $display("FAIL rand_rdata c%0d got %h/%h exp %h", c, inst_rdata, data_rdata, bus_rdata); else n_pass++;
            if (bus_data_ok && q.size() == 0) m_err = 1;
            if (e_pop) void'(q.pop_front());
            if (e_hs) q.push_back(int'(g));
            if (!locked && e_breq && !bus_addr_ok) begin locked = 1; lock_id = g; end
            else if (locked && (bus_addr_ok || !greq)) locked = 0;
            if (!inst_req || (e_hs && !g)) starve = 0;
            else if (e_hs && g && starve < SLIM) starve++;
            step();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock();
        test_full();
        test_starvation();
        test_orphan();
        test_reset_mid_lock();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
